// File: rtl/edge_event_arbiter.sv
// Purpose : synchronise N_CH async levels, detect per-channel edges, queue one event per channel, hand them out round-robin.
// Latency : SYNC_STAGES+3 clock edges from the first edge that samples a changed input to evt_valid (5 at default).
// Backpress: evt_valid/evt_id/evt_rise hold while evt_ready=0; a second edge on a channel whose event is still queued is dropped and flagged in overflow.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   sig[N_CH]          raw asynchronous level inputs
//   edge_sel[2*N_CH]   per-channel mode at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   evt_valid/evt_ready, evt_id, evt_rise   event handshake, channel index and polarity (1 rising)
//   pending[N_CH]      per-channel queued-event flags
//   overflow[N_CH]     sticky per-channel dropped-event flags, cleared by ovf_clr
module edge_event_arbiter #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     sig,
    input  logic [2*N_CH-1:0]   edge_sel,
    output logic                evt_valid,
    output logic [IDW-1:0]      evt_id,
    output logic                evt_rise,
    input  logic                evt_ready,
    output logic [N_CH-1:0]     pending,
    output logic [N_CH-1:0]     overflow,
    input  logic                ovf_clr
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int AW      = $clog2(ARM_MAX + 1);

    // ------------------------------------------------------------------
    // Synchroniser chain, delay flop and arm counter
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] r_dly;
    logic [AW-1:0]   r_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_dly <= '0;
            r_arm <= '0;
        end else begin
            r_sync[0] <= sig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_dly <= r_sync[SYNC_STAGES-1];
            if (r_arm != AW'(ARM_MAX)) begin
                r_arm <= r_arm + 1'b1;
            end
        end
    end

    // The chain and delay flop come out of reset at 0, so an input held high
    // through reset looks like a rising edge a few cycles later; the arm
    // counter masks that window.
    logic            w_armed;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_qe;

    assign w_armed = (r_arm == AW'(ARM_MAX));
    assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign w_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

    always_comb begin
        w_qe = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_qe[i] = w_armed & ((edge_sel[2*i]   & w_rise[i]) |
                                 (edge_sel[2*i+1] & w_fall[i]));
        end
    end

    // Registered qualified edge and its polarity.
    logic [N_CH-1:0] r_qe;
    logic [N_CH-1:0] r_qpol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qe   <= '0;
            r_qpol <= '0;
        end else begin
            r_qe   <= w_qe;
            r_qpol <= w_rise;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection among pending channels
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_pol;
    logic [N_CH-1:0] r_overflow;
    logic [IDW-1:0]  r_last;
    logic            r_valid;
    logic [IDW-1:0]  r_id;
    logic            r_rise;

    logic            w_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_idx;
    logic            w_load;
    logic [N_CH-1:0] w_gnt_oh;

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = IDW'((int'(r_last) + k) % N_CH);
            if (!w_found && r_pending[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    // Output slot is free when empty or being drained this cycle, which lets
    // back-to-back events stream without a bubble.
    assign w_load   = (!r_valid || evt_ready) && w_found;
    assign w_gnt_oh = w_load ? ({{(N_CH-1){1'b0}}, 1'b1} << w_gnt_id) : '0;

    // ------------------------------------------------------------------
    // Per-channel queue and overflow next state
    // ------------------------------------------------------------------
    logic [N_CH-1:0] w_pend_nxt;
    logic [N_CH-1:0] w_pol_nxt;
    logic [N_CH-1:0] w_ovf_nxt;

    always_comb begin
        w_pend_nxt = r_pending;
        w_pol_nxt  = r_pol;
        w_ovf_nxt  = ovf_clr ? '0 : r_overflow;
        for (int i = 0; i < N_CH; i++) begin
            if (r_qe[i] && (!r_pending[i] || w_gnt_oh[i])) begin
                // Free slot, or slot vacated by this cycle's grant: store it.
                w_pend_nxt[i] = 1'b1;
                w_pol_nxt[i]  = r_qpol[i];
            end else if (r_qe[i]) begin
                // Slot still occupied: keep the older event, drop this one.
                w_ovf_nxt[i]  = 1'b1;
            end else if (w_gnt_oh[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_pol      <= '0;
            r_overflow <= '0;
            r_last     <= IDW'(N_CH - 1);
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_rise     <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_pol      <= w_pol_nxt;
            r_overflow <= w_ovf_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
                r_id    <= w_gnt_id;
                r_rise  <= r_pol[w_gnt_id];
                r_last  <= w_gnt_id;
            end else if (r_valid && evt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign evt_rise  = r_rise;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter at N_CH=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig;
    logic [7:0] edge_sel;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_rise;
    logic       evt_ready;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    int seen;

    edge_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig       (sig),
        .edge_sel  (edge_sel),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_rise  (evt_rise),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        sig       = 4'b0010;
        edge_sel  = 8'h08;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1 rst_n  = 1'b0;
        step(3);

        // Reset state
        chk("rst_valid",    32'(evt_valid), 32'd0);
        chk("rst_id",       32'(evt_id),    32'd0);
        chk("rst_rise",     32'(evt_rise),  32'd0);
        chk("rst_pending",  32'(pending),   32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);

        // sig[1] high through reset release, falling mode: no event
        rst_n = 1'b1;
        step(10);
        chk("held_valid",   32'(evt_valid), 32'd0);
        chk("held_pending", 32'(pending),   32'd0);
        sig = 4'b0000;
        step(4);
        chk("fall_early",   32'(evt_valid), 32'd0);
        step(1);
        chk("fall_valid",   32'(evt_valid), 32'd1);
        chk("fall_id",      32'(evt_id),    32'd1);
        chk("fall_rise",    32'(evt_rise),  32'd0);
        evt_ready = 1'b1;
        step(1);
        chk("fall_done",    32'(evt_valid), 32'd0);

        // Single rising edge on ch0: valid exactly at edge 5, for one cycle
        edge_sel = 8'h01;
        sig      = 4'b0001;
        step(4);
        chk("lat_edge4",    32'(evt_valid), 32'd0);
        step(1);
        chk("lat_edge5",    32'(evt_valid), 32'd1);
        chk("lat_id",       32'(evt_id),    32'd0);
        chk("lat_rise",     32'(evt_rise),  32'd1);
        step(1);
        chk("lat_one_cyc",  32'(evt_valid), 32'd0);
        chk("lat_pending",  32'(pending),   32'd0);

        // All channels off: toggling produces nothing
        edge_sel = 8'h00;
        sig = 4'hF; step(2);
        sig = 4'h0; step(2);
        sig = 4'hA; step(3);
        sig = 4'h5; step(3);
        sig = 4'h0; step(6);
        chk("off_pending",  32'(pending),   32'd0);
        chk("off_valid",    32'(evt_valid), 32'd0);
        chk("off_overflow", 32'(overflow),  32'd0);

        // Reset pulse while idle so arbitration restarts at channel 0
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);

        // All channels rise together, consumer stalled then draining
        evt_ready = 1'b0;
        edge_sel  = 8'hFF;
        sig       = 4'hF;
        step(4);
        chk("all_pend",     32'(pending),   32'hF);
        chk("all_nvalid",   32'(evt_valid), 32'd0);
        step(1);
        chk("all_v0",       32'(evt_valid), 32'd1);
        chk("all_id0",      32'(evt_id),    32'd0);
        chk("all_pend_e",   32'(pending),   32'hE);
        step(9);
        chk("hold_valid",   32'(evt_valid), 32'd1);
        chk("hold_id",      32'(evt_id),    32'd0);
        chk("hold_rise",    32'(evt_rise),  32'd1);
        evt_ready = 1'b1;
        step(1);
        chk("all_v1",       32'(evt_valid), 32'd1);
        chk("all_id1",      32'(evt_id),    32'd1);
        step(1);
        chk("all_v2",       32'(evt_valid), 32'd1);
        chk("all_id2",      32'(evt_id),    32'd2);
        step(1);
        chk("all_v3",       32'(evt_valid), 32'd1);
        chk("all_id3",      32'(evt_id),    32'd3);
        chk("all_pend_0",   32'(pending),   32'd0);
        step(1);
        chk("all_end",      32'(evt_valid), 32'd0);
        edge_sel = 8'h00;
        sig      = 4'h0;
        step(6);

        // Both-edge mode on ch3: one pulse gives a rise then a fall event
        edge_sel = 8'hC0;
        sig      = 4'b1000;
        step(4);
        sig      = 4'b0000;
        step(1);
        chk("both_rv",      32'(evt_valid), 32'd1);
        chk("both_rid",     32'(evt_id),    32'd3);
        chk("both_rr",      32'(evt_rise),  32'd1);
        step(1);
        chk("both_gap",     32'(evt_valid), 32'd0);
        step(3);
        chk("both_fv",      32'(evt_valid), 32'd1);
        chk("both_fid",     32'(evt_id),    32'd3);
        chk("both_fr",      32'(evt_rise),  32'd0);
        step(1);
        chk("both_end",     32'(evt_valid), 32'd0);
        edge_sel = 8'h00;
        step(2);

        // Overflow: ch0 event occupies the output, ch2 rises twice 8 cycles apart
        evt_ready = 1'b0;
        edge_sel  = 8'h11;
        sig       = 4'b0001;
        step(5);
        chk("ovf_v0",       32'(evt_valid), 32'd1);
        chk("ovf_id0",      32'(evt_id),    32'd0);
        sig = 4'b0101;
        step(4);
        chk("ovf_pend1",    32'(pending),   32'h4);
        chk("ovf_none",     32'(overflow),  32'h0);
        sig = 4'b0001;
        step(4);
        sig = 4'b0101;
        step(4);
        chk("ovf_set",      32'(overflow),  32'h4);
        chk("ovf_pend2",    32'(pending),   32'h4);
        chk("ovf_hold_id",  32'(evt_id),    32'd0);
        evt_ready = 1'b1;
        step(1);
        chk("ovf_v2",       32'(evt_valid), 32'd1);
        chk("ovf_id2",      32'(evt_id),    32'd2);
        chk("ovf_rise2",    32'(evt_rise),  32'd1);
        step(1);
        chk("ovf_drain",    32'(evt_valid), 32'd0);
        chk("ovf_pend0",    32'(pending),   32'h0);
        chk("ovf_sticky",   32'(overflow),  32'h4);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr",      32'(overflow),  32'h0);
        edge_sel  = 8'h00;
        sig       = 4'h0;
        step(6);

        // Reset mid-transfer with events queued
        evt_ready = 1'b0;
        edge_sel  = 8'h15;
        sig       = 4'b0111;
        step(5);
        chk("mid_valid",    32'(evt_valid), 32'd1);
        chk("mid_id",       32'(evt_id),    32'd0);
        chk("mid_pend",     32'(pending),   32'h6);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(evt_valid), 32'd0);
        chk("arst_id",      32'(evt_id),    32'd0);
        chk("arst_rise",    32'(evt_rise),  32'd0);
        chk("arst_pend",    32'(pending),   32'd0);
        chk("arst_ovf",     32'(overflow),  32'd0);
        step(2);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        seen      = 0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            if (evt_valid !== 1'b0 || pending !== 4'h0) seen++;
        end
        chk("post_rst_quiet", 32'(seen),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of monitored input channels (2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth per channel (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sig  input  N_CH  raw asynchronous level inputs, one per channel.
REQ-006 SHALL have port edge_sel  input  2*N_CH  per-channel mode at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 SHALL have port evt_valid  output  1  event available.
REQ-008 SHALL have port evt_id  output  IDW=max(1,ceil(log2 N_CH))  channel index of event.
REQ-009 SHALL have port evt_rise  output  1  event polarity: 1 rising, 0 falling.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-011 SHALL have port pending  output  N_CH  per-channel queued-event flags.
REQ-012 SHALL have port overflow  output  N_CH  sticky per-channel dropped-event flags.
REQ-013 SHALL have port ovf_clr  input  1  clears all overflow bits.

Function
REQ-014 SHALL pass each sig bit through SYNC_STAGES flops to s[i], plus one delay flop d[i].
REQ-015 SHALL detect rise[i] = s[i] & ~d[i] and fall[i] = ~s[i] & d[i], qualified by edge_sel; qualified edge = qe[i].
REQ-016 SHALL suppress qe for the first SYNC_STAGES+1 cycles after reset release (arm counter), so a level held high through reset produces no event.
REQ-017 SHALL set pending[i] and store polarity pol[i] on the clock edge after qe[i] is asserted.
REQ-018 SHALL load a new event when (evt_valid=0 or evt_valid&evt_ready) and pending!=0: select by round-robin starting at last_grant+1 mod N_CH, drive evt_id/evt_rise from that channel, clear its pending bit, set evt_valid=1, update last_grant, all on the same edge.
REQ-019 SHALL hold evt_id and evt_rise stable while evt_valid=1 and evt_ready=0.
REQ-020 SHALL deassert evt_valid after a transfer (evt_valid&evt_ready) only if pending=0; otherwise SHALL present the next event on the following cycle without a bubble.
REQ-021 SHALL give, from idle, a latency of SYNC_STAGES+3 clock edges from the first edge sampling a changed sig to evt_valid=1 (5 at default).
REQ-022 SHALL, on qe[i] while pending[i]=1 and channel i not granted that cycle, set overflow[i]; stored event is kept, new edge dropped.
REQ-023 SHALL, on qe[i] in the same cycle channel i is granted, keep pending[i]=1 with new polarity and not set overflow.
REQ-024 SHALL clear all overflow bits on ovf_clr; simultaneous set on a channel wins for that channel.
REQ-025 SHALL NOT clear pending or overflow when edge_sel changes; mode 00 only blocks new edges.
REQ-026 SHALL treat both edges of one pulse as two events when mode is 11.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force evt_valid=0, evt_id=0, evt_rise=0, pending=0, overflow=0, all synchronizer/delay flops=0, arm counter=0, last_grant=N_CH-1 (channel 0 first).
REQ-028 SHALL, on reset assertion mid-transfer, discard all queued and presented events; none reappear after release.

Verification (N_CH=4, SYNC_STAGES=2)
REQ-029 SHALL cover: edge_sel=0x01, evt_ready=1, sig[0] 0->1 -> evt_valid=1 for exactly one cycle at edge 5, evt_id=0, evt_rise=1.
REQ-030 SHALL cover: edge_sel=0xFF, all sig rise same cycle, evt_ready=0 for 10 cycles then 1 -> pending=1111, then ids 0,1,2,3 on four consecutive cycles, evt_valid continuous, pending ends 0000.
REQ-031 SHALL cover: evt_ready=0, two rising edges on sig[2] 8 cycles apart -> overflow=0100, one event id=2 rise=1 on ready; ovf_clr pulse -> overflow=0000.
REQ-032 SHALL cover: sig[1]=1 through reset release, edge_sel=0x08 -> no event; sig[1] 1->0 -> event id=1, evt_rise=0.
REQ-033 SHALL cover: evt_valid=1, pending=0110, rst_n pulsed low mid-cycle -> all outputs 0 immediately, no events after release.
REQ-034 SHALL cover: edge_sel=0x00, toggling sig -> pending, evt_valid, overflow stay 0.
